apb_intc: RTL and testbench



---
 rtl/intc_pkg.sv | 32 +++
 rtl/apb_intc_if.sv | 20 ++
 rtl/intc_src_cond.sv | 37 +++
 rtl/apb_intc.sv | 123 ++++++++++++
 tb/tb_apb_intc.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the APB interrupt controller.
//   - APB address width and register word offsets
//   - INTC_MAX_SRC: upper bound on interrupt sources
//   - prio_enc(): lowest-index-wins priority encoder returning {valid, id}
package intc_pkg;

  localparam int unsigned INTC_ADDR_W  = 12;
  localparam int unsigned INTC_MAX_SRC = 32;

  localparam logic [INTC_ADDR_W-1:0] INTC_PENDING = 12'h000;
  localparam logic [INTC_ADDR_W-1:0] INTC_ENABLE  = 12'h004;
  localparam logic [INTC_ADDR_W-1:0] INTC_MODE    = 12'h008;
  localparam logic [INTC_ADDR_W-1:0] INTC_CLAIM   = 12'h00C;
  localparam logic [INTC_ADDR_W-1:0] INTC_SWSET   = 12'h010;

  // Scans from the top down so the lowest set index is the final assignment.
  // id is 0 when nothing is set.
  function automatic logic [5:0] prio_enc(input logic [INTC_MAX_SRC-1:0] vec);
    logic       valid;
    logic [4:0] id;
    valid = 1'b0;
    id    = '0;
    for (int unsigned i = INTC_MAX_SRC; i > 0; i--) begin
      if (vec[i-1]) begin
        valid = 1'b1;
        id    = 5'(i - 1);
      end
    end
    return {valid, id};
  endfunction

endpackage

// File: rtl/apb_intc_if.sv
// apb_intc_if: APB3 bus bundle used by the interrupt controller.
//   paddr/psel/penable/pwrite/pwdata : master -> slave
//   prdata/pready/pslverr            : slave -> master
interface apb_intc_if
  import intc_pkg::*;
();
  logic [INTC_ADDR_W-1:0] paddr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            pwdata;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/intc_src_cond.sv
// intc_src_cond: conditions one asynchronous interrupt source.
//   clk, rstn_i : clock, asynchronous active-low reset
//   src_i       : raw asynchronous source
//   s_o         : synchronised level (last stage of the flop chain)
//   rise_o      : one-cycle pulse on a 0->1 transition of s_o
module intc_src_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic src_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/apb_intc.sv
// apb_intc: APB3 interrupt controller with per-source enable and
// level/rising-edge mode.
//   clk, rstn_i : clock, asynchronous active-low reset
//   apb_bus     : APB3 slave (zero wait state)
//   src_i       : N_SRC asynchronous interrupt sources
//   irq_o       : registered core interrupt = |(PENDING & ENABLE)
//   irq_id_o    : registered index of lowest enabled pending source
// Registers are held 32 bits wide with bits >= N_SRC forced to zero.
module apb_intc
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn_i,
  apb_intc_if.slave        apb_bus,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_o,
  output logic [4:0]       irq_id_o
);

  localparam logic [31:0] SRC_MASK =
    (N_SRC >= INTC_MAX_SRC) ? '1 : ((32'd1 << N_SRC) - 32'd1);

  logic [N_SRC-1:0] s, rise;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    intc_src_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clk    (clk),
      .rstn_i (rstn_i),
      .src_i  (src_i[i]),
      .s_o    (s[i]),
      .rise_o (rise[i])
    );
  end

  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q,  enable_d;
  logic [31:0] mode_q,    mode_d;
  logic        irq_q,     irq_d;
  logic [4:0]  irq_id_q,  irq_id_d;

  logic        access, wr_acc, rd_acc, mapped;
  logic        sel_pending, sel_enable, sel_mode, sel_claim, sel_swset;
  logic [31:0] wdata_m, s32, rise32;
  logic [31:0] w1c, swset, claim_oh, mode_chg, edge_next;
  logic [5:0]  win;

  assign s32    = 32'(s);
  assign rise32 = 32'(rise);

  always_comb begin
    access      = apb_bus.psel & apb_bus.penable;
    wr_acc      = access & apb_bus.pwrite;
    rd_acc      = access & ~apb_bus.pwrite;
    sel_pending = (apb_bus.paddr == INTC_PENDING);
    sel_enable  = (apb_bus.paddr == INTC_ENABLE);
    sel_mode    = (apb_bus.paddr == INTC_MODE);
    sel_claim   = (apb_bus.paddr == INTC_CLAIM);
    sel_swset   = (apb_bus.paddr == INTC_SWSET);
    mapped      = sel_pending | sel_enable | sel_mode | sel_claim | sel_swset;
    wdata_m     = apb_bus.pwdata & SRC_MASK;
    win         = prio_enc(pending_q & enable_q);
  end

  // Read mux: combinational from current state, zero outside a read access.
  always_comb begin
    apb_bus.prdata = '0;
    if (rd_acc) begin
      if (sel_pending)     apb_bus.prdata = pending_q;
      else if (sel_enable) apb_bus.prdata = enable_q;
      else if (sel_mode)   apb_bus.prdata = mode_q;
      else if (sel_claim)  apb_bus.prdata = win[5] ? 32'(win[4:0]) + 32'd1 : '0;
    end
  end

  assign apb_bus.pready  = 1'b1;
  assign apb_bus.pslverr = access & ~mapped;

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    swset    = '0;
    claim_oh = '0;
    mode_chg = '0;
    if (wr_acc && sel_enable) enable_d = wdata_m;
    if (wr_acc && sel_mode) begin
      mode_d   = wdata_m;
      mode_chg = wdata_m ^ mode_q;
    end
    if (wr_acc && sel_pending) w1c   = wdata_m;
    if (wr_acc && sel_swset)   swset = wdata_m;
    if (rd_acc && sel_claim && win[5]) claim_oh = 32'd1 << win[4:0];
    // Sets are OR'd after the clear so a coincident hardware set wins.
    edge_next = (pending_q & ~(w1c | claim_oh)) | swset | rise32;
    // Level bits follow s; any bit whose mode is being rewritten is cleared.
    pending_d = ((mode_q & edge_next) | (~mode_q & s32)) & ~mode_chg & SRC_MASK;
    irq_d     = |(pending_q & enable_q);
    irq_id_d  = win[4:0];
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_apb_intc.sv
// tb_apb_intc: self-checking bench for apb_intc. APB transfers push their
// expected response to a scoreboard queue; a monitor pops and compares in
// the access phase. A vector table covers register basics, followed by
// hand-written multi-cycle sequences.
module tb_apb_intc;
  import intc_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned SS = 2;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   src  = '0;
  logic           irq;
  logic [4:0]     irq_id;

  apb_intc_if bus ();

  always #5 clk = ~clk;

  apb_intc #(.N_SRC(N), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rstn_i   (rstn),
    .apb_bus  (bus.slave),
    .src_i    (src),
    .irq_o    (irq),
    .irq_id_o (irq_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] exp;
    logic        err;
  } sb_t;

  sb_t sbq[$];
  sb_t sb_e;

  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: transfer with no expectation queued");
      end else begin
        sb_e = sbq.pop_front();
        chk({sb_e.name, " pslverr"}, 32'(bus.pslverr), 32'(sb_e.err));
        chk({sb_e.name, " pready"}, 32'(bus.pready), 32'd1);
        if (!sb_e.wr) chk({sb_e.name, " prdata"}, bus.prdata, sb_e.exp);
      end
    end
  end

  // Entered and left at #1 after a rising edge.
  task automatic xfer(input string name, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    sbq.push_back('{name, wr, exp, err});
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = wdata;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic wr(input string name, input logic [11:0] addr, input logic [31:0] d);
    xfer(name, 1'b1, addr, d, 32'd0, 1'b0);
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    xfer(name, 1'b0, addr, 32'd0, exp, 1'b0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"rst PENDING",  1'b0, INTC_PENDING, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{"rst ENABLE",   1'b0, INTC_ENABLE,  32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{"rst MODE",     1'b0, INTC_MODE,    32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{"rst CLAIM",    1'b0, INTC_CLAIM,   32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{"rd SWSET",     1'b0, INTC_SWSET,   32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{"wr ENABLE",    1'b1, INTC_ENABLE,  32'hFFFF_FFFF, 32'h0, 1'b0});
    vecs.push_back('{"ENABLE bound", 1'b0, INTC_ENABLE,  32'h0, 32'h0000_FFFF, 1'b0});
    vecs.push_back('{"wr MODE",      1'b1, INTC_MODE,    32'h0000_A5A5, 32'h0, 1'b0});
    vecs.push_back('{"rd MODE",      1'b0, INTC_MODE,    32'h0, 32'h0000_A5A5, 1'b0});
    vecs.push_back('{"rd 0x14",      1'b0, 12'h014,      32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{"wr 0x14",      1'b1, 12'h014,      32'h1234_5678, 32'h0, 1'b1});
    vecs.push_back('{"rd 0x18",      1'b0, 12'h018,      32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{"ENABLE kept",  1'b0, INTC_ENABLE,  32'h0, 32'h0000_FFFF, 1'b0});
    vecs.push_back('{"SWSET 0x3",    1'b1, INTC_SWSET,   32'h0000_0003, 32'h0, 1'b0});
    vecs.push_back('{"PEND swset",   1'b0, INTC_PENDING, 32'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{"CLAIM src0",   1'b0, INTC_CLAIM,   32'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{"PEND claimed", 1'b0, INTC_PENDING, 32'h0, 32'h0000_0000, 1'b0});

    bus.paddr = '0; bus.psel = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0; bus.pwdata = '0;

    cyc(2);
    rstn = 1'b1;
    chk("reset irq_o", 32'(irq), 32'd0);
    chk("reset irq_id_o", 32'(irq_id), 32'd0);
    chk("reset pready", 32'(bus.pready), 32'd1);
    chk("reset pslverr", 32'(bus.pslverr), 32'd0);
    chk("reset prdata", bus.prdata, 32'd0);
    cyc(SS + 2);

    foreach (vecs[i])
      xfer(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].err);

    // Asynchronous reset mid-cycle with irq asserted.
    wr("SWSET pre-reset", INTC_SWSET, 32'h1);
    cyc(1);
    chk("irq before reset", 32'(irq), 32'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("async reset irq_o", 32'(irq), 32'd0);
    chk("async reset irq_id_o", 32'(irq_id), 32'd0);
    cyc(1);
    rstn = 1'b1;
    rd("post-rst ENABLE", INTC_ENABLE, 32'h0);
    rd("post-rst MODE", INTC_MODE, 32'h0);
    rd("post-rst PENDING", INTC_PENDING, 32'h0);

    // A source already high when edge mode is selected does not fire.
    src[3] = 1'b1;
    cyc(SS + 2);
    wr("MODE held src", INTC_MODE, 32'h8);
    cyc(SS + 2);
    rd("held src no edge", INTC_PENDING, 32'h0);
    src[3] = 1'b0;
    cyc(SS + 2);

    // Edge path with exact latency.
    wr("edge MODE", INTC_MODE, 32'h8);
    wr("edge ENABLE", INTC_ENABLE, 32'h8);
    src[3] = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) src[3] = 1'b0;
      if (k == SS + 1) chk("edge irq not yet", 32'(irq), 32'd0);
      if (k == SS + 2) begin
        chk("edge irq", 32'(irq), 32'd1);
        chk("edge irq_id", 32'(irq_id), 32'd3);
      end
    end
    rd("edge PENDING", INTC_PENDING, 32'h8);
    rd("edge CLAIM", INTC_CLAIM, 32'h4);
    chk("irq held after claim", 32'(irq), 32'd1);
    cyc(1);
    chk("irq falls after claim", 32'(irq), 32'd0);
    chk("irq_id after claim", 32'(irq_id), 32'd0);
    rd("edge PENDING cleared", INTC_PENDING, 32'h0);

    // Level mode and priority.
    wr("level MODE", INTC_MODE, 32'h0);
    wr("level ENABLE", INTC_ENABLE, 32'h24);
    src[2] = 1'b1;
    src[5] = 1'b1;
    cyc(SS + 2);
    chk("level irq", 32'(irq), 32'd1);
    chk("level irq_id 2", 32'(irq_id), 32'd2);
    rd("level CLAIM a", INTC_CLAIM, 32'h3);
    rd("level CLAIM b", INTC_CLAIM, 32'h3);
    rd("level PENDING", INTC_PENDING, 32'h24);
    src[2] = 1'b0;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge clk); #1;
      if (k == SS + 1) chk("level id still 2", 32'(irq_id), 32'd2);
      if (k == SS + 2) chk("level id 5", 32'(irq_id), 32'd5);
    end
    src[5] = 1'b0;
    cyc(SS + 2);
    chk("level irq drop", 32'(irq), 32'd0);

    // Hardware set landing in the same cycle as W1C.
    wr("race MODE", INTC_MODE, 32'h2);
    wr("race ENABLE", INTC_ENABLE, 32'h0);
    src[1] = 1'b1;
    cyc(1);
    src[1] = 1'b0;
    cyc(SS + 2);
    rd("race pre PENDING", INTC_PENDING, 32'h2);
    src[1] = 1'b1;
    cyc(SS - 1);
    wr("race W1C", INTC_PENDING, 32'h2);
    rd("race set wins", INTC_PENDING, 32'h2);
    wr("plain W1C", INTC_PENDING, 32'h2);
    rd("W1C clears", INTC_PENDING, 32'h0);
    src[1] = 1'b0;
    cyc(SS + 2);

    // Masking, late enable, SWSET, MODE-change clear.
    wr("mask MODE", INTC_MODE, 32'h11);
    src[0] = 1'b1;
    cyc(1);
    src[0] = 1'b0;
    cyc(SS + 2);
    chk("masked irq", 32'(irq), 32'd0);
    rd("masked PENDING", INTC_PENDING, 32'h1);
    wr("late ENABLE", INTC_ENABLE, 32'h1);
    chk("irq not same edge", 32'(irq), 32'd0);
    cyc(1);
    chk("irq after enable", 32'(irq), 32'd1);
    chk("irq_id src0", 32'(irq_id), 32'd0);
    wr("SWSET 0x30", INTC_SWSET, 32'h30);
    rd("SWSET PENDING", INTC_PENDING, 32'h11);
    wr("MODE bit4 level", INTC_MODE, 32'h01);
    rd("mode change clear", INTC_PENDING, 32'h1);
    rd("mask CLAIM", INTC_CLAIM, 32'h1);
    rd("mask PENDING end", INTC_PENDING, 32'h0);

    cyc(2);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
